// File: rtl/beat_tone_synth.sv
// beat_tone_synth: per-beat square-wave tone generator with repeat-note gap,
// volume scaling and a 16-bit stereo I2S serializer (same mono word on L/R).
module beat_tone_synth #(
    parameter int unsigned GAP_CYCLES = 1000000,  // silence before a repeated note
    parameter int unsigned GAP_W      = 20        // GAP_CYCLES must be < 2**GAP_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [11:0] ibeat,
    input  logic [21:0] tone_div,
    input  logic [2:0]  volume,
    input  logic        mute,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin,
    output logic        playing
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_PLAY,
        S_REST
    } state_e;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Tone state
    state_e            state_q, state_d;
    logic [21:0]       cur_div_q, cur_div_d;
    logic [21:0]       tone_cnt_q, tone_cnt_d;
    logic              phase_q, phase_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    // Beat detection history
    logic [11:0]       prev_ibeat_q;
    logic              en_q;
    logic              new_beat;

    // Serializer state
    logic [8:0]        cnt_q;
    logic [15:0]       frame_q;
    logic              hold_q;
    logic              sdin_q;

    logic [15:0]       amp;
    logic [15:0]       sample;
    logic [4:0]        slot;
    logic [3:0]        bit_idx;
    logic              hold_bit;
    logic              sdin_d;

    // A beat starts on enable rising or whenever the beat index moves.
    assign new_beat = en && (!en_q || (ibeat != prev_ibeat_q));

    // Remember last cycle's enable and beat index for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q         <= 1'b0;
            prev_ibeat_q <= '0;
        end else begin
            // NOTE: clocked blocks use non-blocking assignments so every
            // register in the design samples values from before the edge.
            en_q         <= en;
            prev_ibeat_q <= ibeat;
        end
    end

    // FSM and tone-generator state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_div_q  <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state: disable wins, then a new beat, then gap expiry / tone toggle.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no
        // branch below can leave one unassigned and infer a latch.
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        gap_cnt_d  = gap_cnt_q;

        if (!en) begin
            state_d    = S_IDLE;
            cur_div_d  = '0;
            tone_cnt_d = '0;
            phase_d    = 1'b0;
            gap_cnt_d  = '0;
        end else if (new_beat) begin
            cur_div_d  = tone_div;
            tone_cnt_d = '0;
            phase_d    = 1'b0;
            gap_cnt_d  = '0;
            if (tone_div == '0) begin
                state_d = S_REST;
            end else if (tone_div == cur_div_q) begin
                // Same pitch again: insert silence so the notes stay distinct.
                state_d = S_GAP;
            end else begin
                state_d = S_PLAY;
            end
        end else begin
            unique case (state_q)
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d    = S_PLAY;
                        tone_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (tone_cnt_q == cur_div_q - 22'd1) begin
                        tone_cnt_d = '0;
                        phase_d    = ~phase_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 22'd1;
                    end
                end
                default: begin
                    // IDLE and REST hold until the next beat.
                end
            endcase
        end
    end

    // Square-wave sample scaled by volume; silent outside PLAY or when muted.
    always_comb begin
        amp    = 16'h0080 << volume;
        sample = '0;
        if ((state_q == S_PLAY) && !mute && (volume != 3'd0)) begin
            sample = phase_q ? amp : (16'h0000 - amp);
        end
    end

    assign slot = cnt_q[8:4];

    // Pick the bit for the current slot: slot 0 carries the previous right
    // word's LSB, then left MSB-first, then right bits 15..1.
    always_comb begin
        // At cnt 0 the hold register is being loaded this very edge, so take
        // the bit straight from the outgoing frame to keep slot 0 consistent.
        hold_bit = (cnt_q == 9'd0) ? frame_q[0] : hold_q;
        if (slot <= 5'd16) begin
            bit_idx = 4'(5'd16 - slot);
        end else begin
            bit_idx = 4'(5'd0 - slot);
        end
        if (slot == 5'd0) begin
            sdin_d = hold_bit;
        end else begin
            sdin_d = frame_q[bit_idx];
        end
    end

    // Free-running frame counter, frame latch and registered serial data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            // NOTE: the frame latch is an ordinary register and is cleared on
            // reset, so the first frame after reset always carries silence.
            frame_q <= '0;
            hold_q  <= 1'b0;
            sdin_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 9'd1;
            if (cnt_q == 9'd0) begin
                frame_q <= sample;
                hold_q  <= frame_q[0];
            end
            sdin_q <= sdin_d;
        end
    end

    assign audio_mclk = cnt_q[1];
    assign audio_sck  = cnt_q[3];
    assign audio_lrck = cnt_q[8];
    assign audio_sdin = sdin_q;
    assign playing    = (state_q == S_PLAY);

endmodule

// File: tb/tb_beat_tone_synth.sv
// Self-checking bench for beat_tone_synth: a time-since-beat behavioural
// model plus frame capture, directed scenarios and a randomized phase.
module tb_beat_tone_synth;

    localparam int G  = 16;
    localparam int GW = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [11:0] ibeat = '0;
    logic [21:0] tone_div = '0;
    logic [2:0]  volume = '0;
    logic        mute = 1'b0;
    logic        audio_mclk, audio_sck, audio_lrck, audio_sdin, playing;

    int n_checks = 0;
    int n_fail   = 0;

    beat_tone_synth #(.GAP_CYCLES(G), .GAP_W(GW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ibeat      (ibeat),
        .tone_div   (tone_div),
        .volume     (volume),
        .mute       (mute),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A note is described by its kind, its pitch and its age in clk since the
    // beat that started it; phase is derived from age by division.
    typedef enum int {K_IDLE, K_PLAY, K_GAP, K_REST} kind_e;

    kind_e       m_kind = K_IDLE;
    int          m_age = 0;
    logic [21:0] m_div = '0;
    logic        m_en_d = 1'b0;
    logic [11:0] m_prev_ibeat = '0;
    int          m_cnt = 0;
    logic [15:0] m_word_cur = '0;
    logic [15:0] m_word_prev = '0;
    logic        m_sdin = 1'b0;

    function automatic logic m_playing();
        return (m_kind == K_PLAY) || ((m_kind == K_GAP) && (m_age >= G));
    endfunction

    function automatic logic m_phase();
        int t;
        if (!m_playing() || (m_div == '0)) return 1'b0;
        t = (m_kind == K_GAP) ? (m_age - G) : m_age;
        return ((t / int'(m_div)) % 2) == 1;
    endfunction

    function automatic logic [15:0] m_sample();
        logic [15:0] a;
        a = 16'h0080 << volume;
        if (!m_playing() || mute || (volume == 3'd0)) return 16'h0000;
        return m_phase() ? a : (16'h0000 - a);
    endfunction

    task automatic model_step();
        logic [15:0] smp;
        int          slot;
        logic        nb;
        if (reset) begin
            m_kind = K_IDLE; m_age = 0; m_div = '0; m_en_d = 1'b0; m_prev_ibeat = '0;
            m_cnt = 0; m_word_cur = '0; m_word_prev = '0; m_sdin = 1'b0;
        end else begin
            smp = m_sample();
            if (m_cnt == 0) begin
                m_word_prev = m_word_cur;
                m_word_cur  = smp;
            end
            slot = m_cnt / 16;
            if (slot == 0)       m_sdin = m_word_prev[0];
            else if (slot <= 16) m_sdin = m_word_cur[16 - slot];
            else                 m_sdin = m_word_cur[32 - slot];
            m_cnt = (m_cnt + 1) % 512;

            nb = en && (!m_en_d || (ibeat != m_prev_ibeat));
            if (!en) begin
                m_kind = K_IDLE; m_div = '0; m_age = 0;
            end else if (nb) begin
                if (tone_div == '0)         m_kind = K_REST;
                else if (tone_div == m_div) m_kind = K_GAP;
                else                        m_kind = K_PLAY;
                m_div = tone_div;
                m_age = 0;
            end else begin
                m_age++;
            end
            m_en_d       = en;
            m_prev_ibeat = ibeat;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // ---------------- compare + frame capture ----------------
    logic [15:0] sreg = '0, cap_left = '0, cap_l = '0, cap_r = '0;

    initial forever begin
        int s;
        @(negedge clk);
        check("mclk",    32'(audio_mclk),     32'((m_cnt / 2) % 2));
        check("sck",     32'(audio_sck),      32'((m_cnt / 8) % 2));
        check("lrck",    32'(audio_lrck),     32'((m_cnt / 256) % 2));
        check("sdin",    32'(audio_sdin),     32'(m_sdin));
        check("playing", 32'(playing),        32'(m_playing()));
        check("phase",   32'(dut.phase_q),    32'(m_phase()));
        check("cur_div", 32'(dut.cur_div_q),  32'(m_div));
        if ((m_cnt % 16) == 8) begin
            s    = m_cnt / 16;
            sreg = {sreg[14:0], audio_sdin};
            if (s == 16) cap_left = sreg;
            if (s == 0) begin
                cap_l = cap_left;
                cap_r = sreg;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [21:0] pick_tone();
        logic [21:0] tbl [8];
        tbl = '{22'd0, 22'd1, 22'd2, 22'd3, 22'd7, 22'd10, 22'd25, 22'd100};
        return tbl[$urandom_range(0, 7)];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int r;
        #1 reset = 1'b1;
        en = 1'b0; volume = 3'd7;
        cyc(3);
        reset = 1'b0;

        // Idle: silence and free-running clocks
        cyc(2048);
        check("idle_left",  32'(cap_l), 32'h0);
        check("idle_right", 32'(cap_r), 32'h0);
        check("idle_playing", 32'(playing), 32'd0);

        // Single note, volume 1
        ibeat = 12'd0; tone_div = 22'd10; volume = 3'd1; en = 1'b1;
        cyc(1100);
        check("note_playing", 32'(playing), 32'd1);
        check("note_left",  32'((cap_l == 16'hFF00) || (cap_l == 16'h0100)), 32'd1);
        check("note_right", 32'((cap_r == 16'hFF00) || (cap_r == 16'h0100)), 32'd1);

        // Repeated note: 16 clk of gap, then PLAY with phase restarting
        ibeat = 12'd1;
        for (int i = 0; i < G; i++) begin
            cyc(1);
            check("gap_silent", 32'(playing), 32'd0);
        end
        cyc(1);
        check("gap_end_play",  32'(playing), 32'd1);
        check("gap_end_phase", 32'(dut.phase_q), 32'd0);
        cyc(10);
        check("gap_first_toggle", 32'(dut.phase_q), 32'd1);
        cyc(600);

        // Note change: immediate PLAY, 25-clk half period
        ibeat = 12'd2; tone_div = 22'd25;
        cyc(1);
        check("chg_play",  32'(playing), 32'd1);
        check("chg_div",   32'(dut.cur_div_q), 32'd25);
        cyc(24);
        check("chg_phase_hold", 32'(dut.phase_q), 32'd0);
        cyc(1);
        check("chg_phase_tog",  32'(dut.phase_q), 32'd1);
        cyc(600);

        // Rest
        ibeat = 12'd3; tone_div = 22'd0;
        cyc(1);
        check("rest_playing", 32'(playing), 32'd0);
        cyc(1100);
        check("rest_left",  32'(cap_l), 32'h0);
        check("rest_right", 32'(cap_r), 32'h0);

        // New beat on the gap-expiry clock wins
        ibeat = 12'd4; tone_div = 22'd10;
        cyc(50);
        ibeat = 12'd5;
        cyc(G);
        ibeat = 12'd6; tone_div = 22'd7;
        cyc(1);
        check("prio_play",  32'(playing), 32'd1);
        check("prio_div",   32'(dut.cur_div_q), 32'd7);
        check("prio_phase", 32'(dut.phase_q), 32'd0);
        cyc(7);
        check("prio_toggle", 32'(dut.phase_q), 32'd1);

        // Enable dropped during a gap
        ibeat = 12'd7;
        cyc(5);
        en = 1'b0;
        cyc(1);
        check("drop_idle", 32'(playing), 32'd0);
        check("drop_div",  32'(dut.cur_div_q), 32'd0);
        cyc(20);
        en = 1'b1;
        cyc(600);

        // Mute then loud
        ibeat = 12'd8; tone_div = 22'd10; volume = 3'd3;
        cyc(100);
        mute = 1'b1;
        cyc(1100);
        check("mute_left",    32'(cap_l), 32'h0);
        check("mute_right",   32'(cap_r), 32'h0);
        check("mute_playing", 32'(playing), 32'd1);
        mute = 1'b0; volume = 3'd7;
        cyc(1100);
        check("loud_left",  32'((cap_l == 16'h4000) || (cap_l == 16'hC000)), 32'd1);
        check("loud_right", 32'((cap_r == 16'h4000) || (cap_r == 16'hC000)), 32'd1);

        // Randomized beats, pitches, volume, mute, enable and resets
        for (int k = 0; k < 60; k++) begin
            r      = int'($urandom_range(0, 99));
            mute   = ($urandom_range(0, 5) == 0);
            volume = 3'($urandom_range(0, 7));
            if (r < 8) begin
                en = ~en;
            end else if (r < 12) begin
                #2 reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end else if (r < 20) begin
                tone_div = pick_tone();
            end else begin
                ibeat = ibeat + 12'($urandom_range(1, 3));
                if ($urandom_range(0, 2) != 0) tone_div = pick_tone();
            end
            cyc(int'($urandom_range(3, 700)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beat_tone_synth.md
Name: beat_tone_synth

Overview:
- Downstream consumer of the beat counter `ibeat`, in the music playback path.
- Each beat it takes a tone half-period word `tone_div` and produces a square wave, with a silence gap that separates repeated notes.
- Scales the wave by a volume setting.
- Serialises the 16-bit mono sample to a stereo I2S DAC (PMOD style).

Parameters:
- GAP_CYCLES, 1000000, clk cycles of silence inserted when a beat repeats the previous nonzero tone_div.
- GAP_W, 20, width of the gap counter; must satisfy GAP_CYCLES < 2^GAP_W.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  playback enable; same signal that drives the beat counter.
- ibeat  in  12  current beat index from the beat counter.
- tone_div  in  22  half-period of the tone in clk cycles for the current beat; 0 = rest.
- volume  in  3  0 = silent, 1..7 = amplitude step.
- mute  in  1  forces the sample to 0 without disturbing tone state.
- audio_mclk  out  1  DAC master clock = cnt[1] (clk/4).
- audio_sck  out  1  serial bit clock = cnt[3] (clk/16).
- audio_lrck  out  1  word select = cnt[8] (clk/512); 0 = left, 1 = right.
- audio_sdin  out  1  serial data, registered.
- playing  out  1  high in the PLAY state.

Behaviour:
- Reset values:
  - All registers 0: cnt, state = IDLE, cur_div, tone counter, phase, gap counter, prev_ibeat, en_d, frame sample latch, right-LSB hold, audio_sdin.
  - Consequently every output is 0.
- Beat detect:
  - new_beat = en && (!en_d || ibeat != prev_ibeat).
  - prev_ibeat and en_d are registered every clk.
- FSM states: IDLE, GAP, PLAY, REST.
  - IDLE → entered whenever en = 0, from any state, same clk. It clears tone counter, phase, gap counter and cur_div.
  - On new_beat, from any non-IDLE state or from IDLE with en = 1:
    - tone_div == 0 → REST.
    - tone_div == cur_div (old) and != 0 → GAP, gap counter = 0.
    - otherwise → PLAY.
    - In every case cur_div <= tone_div, tone counter <= 0, phase <= 0.
  - GAP: increment the gap counter each clk. When it reaches GAP_CYCLES-1, go to PLAY with tone counter = 0.
  - PLAY: tone counter increments. When it reaches cur_div-1 it resets to 0 and phase toggles. cur_div = 1 toggles phase every clk.
  - REST: holds until the next new_beat.
  - new_beat has priority over gap expiry and over the tone toggle in the same clk.
- Sample (combinational):
  - amp = 16'h0080 << volume, giving 0x0100 (volume 1) to 0x4000 (volume 7).
  - sample = phase ? +amp : -amp (two's complement), in PLAY only.
  - sample = 0 in IDLE, GAP or REST, or when mute = 1 or volume = 0.
- Serializer: 9-bit free-running cnt runs in every state, including IDLE.
  - At cnt == 0: latch_L = latch_R = sample, and hold <= previous latch_R[0].
  - slot = cnt[8:4], 0..31. Each clk, audio_sdin is registered from the slot of the current cnt, so it is valid 1 clk after the sck falling edge.
  - Slot 0 → hold (LSB of the previous right word; I2S one-bit delay).
  - Slots 1..16 → latch_L[16-slot], MSB first.
  - Slots 17..31 → latch_R[32-slot].
- Latency: a sample change reaches the DAC at the next frame boundary. That is at most 512 clk, plus 1 clk before the MSB appears in slot 1.
- Reset mid-frame: cnt restarts at 0. The first frame after reset carries 0.

Test Plan:
- Idle:
  - Stimulus: reset, en = 0, volume = 7, run 2048 clk.
  - Required: audio_sdin = 0 throughout, mclk/sck/lrck periods of 4/16/512 clk, playing = 0.
- Single note:
  - Stimulus: en = 1, ibeat = 0, tone_div = 10, volume = 1.
  - Required: phase toggles every 10 clk, playing = 1.
  - Required: the next frame shifts left word 0xFF00 or 0x0100 MSB-first in slots 1..16, and the same value in slots 17..31 plus slot 0 of the following frame.
- Repeated note gap (GAP_CYCLES = 16):
  - Stimulus: ibeat 0→1 with tone_div = 10 held.
  - Required: state GAP for exactly 16 clk with sample 0, then PLAY with phase restarting at 0.
- Note change and rest:
  - Stimulus: ibeat 1→2 with tone_div 10→25.
  - Required: immediate PLAY, tone counter reset, toggle every 25 clk.
  - Stimulus: ibeat 2→3 with tone_div = 0.
  - Required: REST, sample 0, playing = 0.
- Priority / simultaneous:
  - Stimulus: new_beat on the same clk the gap counter hits GAP_CYCLES-1 with a new tone_div = 7.
  - Required: goes to PLAY with cur_div = 7 and counter 0.
  - Stimulus: en dropped in GAP.
  - Required: IDLE on the next clk, cur_div = 0.
- Mute/volume:
  - Stimulus: in PLAY, assert mute.
  - Required: next frame is all zero bits, phase keeps toggling.
  - Stimulus: release mute with volume = 7.
  - Required: words are 0x4000 or 0xC000.
